// File: rtl/cfg_axis_pattern_pkg.sv
// Shared constants for the cfg-bus driven AXI-Stream pattern source:
// register word addresses, CTRL/STATUS bit positions, FSM encodings and
// the saturating COUNT increment.
package cfg_axis_pattern_pkg;

  // Register word addresses
  localparam int REG_CTRL   = 0;
  localparam int REG_LENGTH = 1;
  localparam int REG_BASE   = 2;
  localparam int REG_STEP   = 3;
  localparam int REG_STATUS = 4;
  localparam int REG_COUNT  = 5;

  // CTRL bits (write-only, self-clearing pulses)
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // COUNT sticks at all-ones instead of wrapping back to zero
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cfg_axis_pattern.sv
// AXI-Stream arithmetic pattern source programmed over the cfg register bus.
// The CPU writes LENGTH/BASE/STEP, pulses CTRL.start, and the block emits
// BASE, BASE+STEP, ... for LENGTH beats with tlast on the final one.
// Progress is visible through STATUS and COUNT on the registered read port.
//
// Stream handshake: a beat transfers on a rising edge where axis_tvalid and
// axis_tready are both high. Once axis_tvalid is raised it stays high until
// that transfer, and axis_tdata holds steady meanwhile; axis_tlast only ever
// rises while stalled (abort), it never falls. axis_tvalid does not depend on
// axis_tready.
module cfg_axis_pattern
  import cfg_axis_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_wr_data,
  input  logic [CFG_AWIDTH-1:0] cfg_wr_addr,
  input  logic                  cfg_wr_en,
  output logic [CFG_DWIDTH-1:0] cfg_rd_data,
  input  logic [CFG_AWIDTH-1:0] cfg_rd_addr,
  input  logic                  cfg_rd_en,
  output logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  axis_tvalid,
  input  logic                  axis_tready,
  output logic                  axis_tlast,
  output logic [0:0]            dbg_state
);

  // Programmed registers
  logic [31:0]           length_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] step_q;

  // Run state: shadow copies taken at start so mid-run writes cannot disturb it
  logic [0:0]            state_q;
  logic [31:0]           rem_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] step_sh_q;
  logic                  abort_pend_q;

  // Reported status
  logic                  done_q;
  logic                  aborted_q;
  logic [31:0]           count_q;

  logic                  wr_ctrl;
  logic                  start_req;
  logic                  abort_req;
  logic                  busy;
  logic                  last_beat;
  logic                  fire;
  logic [CFG_DWIDTH-1:0] rd_mux;

  assign wr_ctrl   = cfg_wr_en && (cfg_wr_addr == CFG_AWIDTH'(REG_CTRL));
  assign start_req = wr_ctrl && cfg_wr_data[CTRL_START];
  assign abort_req = wr_ctrl && cfg_wr_data[CTRL_ABORT];

  assign busy      = (state_q == ST_RUN);
  // A pending abort turns the beat currently on the bus into the last one
  assign last_beat = busy && ((rem_q == 32'd1) || abort_pend_q);
  assign fire      = busy && axis_tready;

  assign axis_tvalid = busy;
  assign axis_tlast  = last_beat;
  assign axis_tdata  = data_q;
  assign dbg_state   = state_q;

  // R/W configuration registers; CTRL, STATUS, COUNT and unmapped writes fall through
  always_ff @(posedge clk) begin
    if (rst) begin
      length_q <= '0;
      base_q   <= '0;
      step_q   <= '0;
    end else if (cfg_wr_en) begin
      case (cfg_wr_addr)
        CFG_AWIDTH'(REG_LENGTH): length_q <= 32'(cfg_wr_data);
        CFG_AWIDTH'(REG_BASE):   base_q   <= DATA_WIDTH'(cfg_wr_data);
        CFG_AWIDTH'(REG_STEP):   step_q   <= DATA_WIDTH'(cfg_wr_data);
        default: ;
      endcase
    end
  end

  // Run FSM: start loads shadows, each handshake advances the sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      data_q       <= '0;
      step_sh_q    <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Abort alone is ignored here; start wins over a simultaneous abort
          if (start_req) begin
            count_q      <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            if (length_q != 32'd0) begin
              state_q   <= ST_RUN;
              rem_q     <= length_q;
              data_q    <= base_q;
              step_sh_q <= step_q;
              done_q    <= 1'b0;
            end else begin
              // Empty run completes immediately without any beat
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Repeated start is ignored while busy
          if (abort_req) begin
            abort_pend_q <= 1'b1;
          end
          if (fire) begin
            count_q <= sat_inc32(count_q);
            data_q  <= data_q + step_sh_q;
            rem_q   <= rem_q - 32'd1;
            if (last_beat) begin
              state_q      <= ST_IDLE;
              done_q       <= 1'b1;
              aborted_q    <= abort_pend_q;
              abort_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read mux; unmapped addresses and CTRL read as zero
  always_comb begin
    rd_mux = '0;
    case (cfg_rd_addr)
      CFG_AWIDTH'(REG_LENGTH): rd_mux = CFG_DWIDTH'(length_q);
      CFG_AWIDTH'(REG_BASE):   rd_mux = CFG_DWIDTH'(base_q);
      CFG_AWIDTH'(REG_STEP):   rd_mux = CFG_DWIDTH'(step_q);
      CFG_AWIDTH'(REG_STATUS): begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = done_q;
        rd_mux[STAT_ABORTED] = aborted_q;
      end
      CFG_AWIDTH'(REG_COUNT):  rd_mux = CFG_DWIDTH'(count_q);
      default: ;
    endcase
  end

  // Registered read data, zero whenever no read was strobed
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rd_data <= '0;
    end else if (cfg_rd_en) begin
      cfg_rd_data <= rd_mux;
    end else begin
      cfg_rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_axis_pattern.sv
// Directed bench for cfg_axis_pattern. A 32-bit and an 8-bit instance share
// the cfg bus and tready so the wrap case can be compared side by side.
module tb_cfg_axis_pattern;
  import cfg_axis_pattern_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_wr_data;
  logic [4:0]  cfg_wr_addr;
  logic        cfg_wr_en;
  logic [4:0]  cfg_rd_addr;
  logic        cfg_rd_en;
  logic        axis_tready;

  logic [31:0] rd_data32;
  logic [31:0] tdata32;
  logic        tvalid32;
  logic        tlast32;
  logic [0:0]  state32;

  logic [31:0] rd_data8;
  logic [7:0]  tdata8;
  logic        tvalid8;
  logic        tlast8;
  logic [0:0]  state8;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_val;

  cfg_axis_pattern #(.DATA_WIDTH(32), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_en(cfg_wr_en),
    .cfg_rd_data(rd_data32), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_en(cfg_rd_en),
    .axis_tdata(tdata32), .axis_tvalid(tvalid32), .axis_tready(axis_tready),
    .axis_tlast(tlast32), .dbg_state(state32)
  );

  cfg_axis_pattern #(.DATA_WIDTH(8), .CFG_AWIDTH(5), .CFG_DWIDTH(32)) dut8 (
    .clk(clk), .rst(rst),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_en(cfg_wr_en),
    .cfg_rd_data(rd_data8), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_en(cfg_rd_en),
    .axis_tdata(tdata8), .axis_tvalid(tvalid8), .axis_tready(axis_tready),
    .axis_tlast(tlast8), .dbg_state(state8)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: one-cycle write strobe, returns on the negedge after the capturing edge
  task automatic cfg_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 5'(addr);
    cfg_wr_data = data;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
    cfg_wr_data = '0;
  endtask

  // Driver: read strobe, data sampled one edge later
  task automatic cfg_read(input int addr, output logic [31:0] data);
    @(negedge clk);
    cfg_rd_en   = 1'b1;
    cfg_rd_addr = 5'(addr);
    @(negedge clk);
    data      = rd_data32;
    cfg_rd_en = 1'b0;
  endtask

  // Consume beats of the 32-bit instance against exp_q.
  // mode 0: tready always 1; mode 1: tready 1,0,1,0...
  // Stops on a tlast handshake or after max_hs handshakes.
  task automatic stream(input int mode, input int max_hs, input bit chk_hold);
    int          hs;
    int          cyc;
    bit          fin;
    bit          by_last;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] e;
    logic        exp_last;
    hs = 0; cyc = 0; fin = 0; by_last = 0;
    prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    while (!fin) begin
      axis_tready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (chk_hold && prev_stall) begin
        check("hold_data", tdata32, prev_data);
        check("hold_last", tlast32, prev_last);
      end
      if (tvalid32 && axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", tdata32, 64'hDEAD);
          fin = 1;
        end else begin
          e        = exp_q.pop_front();
          exp_last = (exp_q.size() == 0);
          check("beat_data", tdata32, e);
          check("beat_last", tlast32, exp_last);
          hs++;
          if (tlast32) begin
            fin = 1;
            by_last = 1;
          end else if (hs == max_hs) begin
            fin = 1;
          end
        end
      end
      prev_stall = tvalid32 && !axis_tready;
      prev_data  = tdata32;
      prev_last  = tlast32;
      if (!fin) begin
        @(negedge clk);
        cyc++;
        if (cyc > 200) begin
          check("stream_timeout", 0, 1);
          fin = 1;
        end
      end
    end
    if (by_last) begin
      @(negedge clk);
      axis_tready = 1'b0;
      check("valid_drop", tvalid32, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_wr_data = '0; cfg_wr_addr = '0; cfg_wr_en = 1'b0;
    cfg_rd_addr = '0; cfg_rd_en = 1'b0;
    axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", tvalid32, 0);
    check("rst_tlast", tlast32, 0);
    check("rst_tdata", tdata32, 0);
    check("rst_rd_data", rd_data32, 0);
    check("rst_state", state32, ST_IDLE);
    rst = 1'b0;
    cfg_read(REG_STATUS, rd_val); check("rst_status", rd_val, 0);
    cfg_read(REG_LENGTH, rd_val); check("rst_length", rd_val, 0);

    // 1: LENGTH=4 BASE=10 STEP=3, full-rate drain
    cfg_write(REG_LENGTH, 4);
    cfg_write(REG_BASE, 10);
    cfg_write(REG_STEP, 3);
    cfg_read(REG_BASE, rd_val); check("rd_base", rd_val, 10);
    cfg_write(REG_CTRL, 32'h1);
    check("t1_first_valid", tvalid32, 1);
    check("t1_state_run", state32, ST_RUN);
    cfg_read(REG_STATUS, rd_val); check("t1_status_busy", rd_val, 32'h1);
    exp_q = '{32'd10, 32'd13, 32'd16, 32'd19};
    axis_tready = 1'b1;
    stream(0, 100, 1'b0);
    cfg_read(REG_STATUS, rd_val); check("t1_status", rd_val, 32'h2);
    cfg_read(REG_COUNT, rd_val);  check("t1_count", rd_val, 4);
    cfg_read(REG_CTRL, rd_val);   check("t1_ctrl_reads0", rd_val, 0);

    // 2: same run with tready toggling, outputs must hold while stalled
    cfg_write(REG_CTRL, 32'h1);
    exp_q = '{32'd10, 32'd13, 32'd16, 32'd19};
    stream(1, 100, 1'b1);
    cfg_read(REG_COUNT, rd_val); check("t2_count", rd_val, 4);

    // 3: wrap at 8 bits vs. no wrap at 32 bits
    cfg_write(REG_LENGTH, 3);
    cfg_write(REG_BASE, 32'hFE);
    cfg_write(REG_STEP, 1);
    axis_tready = 1'b1;
    cfg_write(REG_CTRL, 32'h1);
    check("t3_b0_d8", tdata8, 8'hFE);  check("t3_b0_l8", tlast8, 0);
    check("t3_b0_d32", tdata32, 32'hFE);
    @(negedge clk);
    check("t3_b1_d8", tdata8, 8'hFF);  check("t3_b1_l8", tlast8, 0);
    @(negedge clk);
    check("t3_b2_d8", tdata8, 8'h00);  check("t3_b2_l8", tlast8, 1);
    check("t3_b2_d32", tdata32, 32'h100); check("t3_b2_l32", tlast32, 1);
    @(negedge clk);
    check("t3_drop8", tvalid8, 0);
    axis_tready = 1'b0;

    // 4: abort after 5 handshakes while stalled
    cfg_write(REG_LENGTH, 100);
    cfg_write(REG_BASE, 5);
    cfg_write(REG_STEP, 2);
    cfg_write(REG_CTRL, 32'h1);
    exp_q = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd13, 32'd15};
    stream(0, 5, 1'b0);
    @(negedge clk);
    axis_tready = 1'b0;
    check("t4_pre_last", tlast32, 0);
    cfg_write(REG_CTRL, 32'h2);
    check("t4_valid_kept", tvalid32, 1);
    check("t4_forced_last", tlast32, 1);
    check("t4_pending_data", tdata32, exp_q.pop_front());
    axis_tready = 1'b1;
    @(negedge clk);
    axis_tready = 1'b0;
    check("t4_valid_drop", tvalid32, 0);
    cfg_read(REG_COUNT, rd_val);  check("t4_count", rd_val, 6);
    cfg_read(REG_STATUS, rd_val); check("t4_status", rd_val, 32'h6);
    cfg_write(REG_CTRL, 32'h2);
    check("t4_idle_abort", state32, ST_IDLE);

    // 5: empty run, then start during a run
    cfg_write(REG_LENGTH, 0);
    cfg_write(REG_CTRL, 32'h1);
    check("t5_no_valid", tvalid32, 0);
    cfg_read(REG_STATUS, rd_val); check("t5_status", rd_val, 32'h2);
    cfg_read(REG_COUNT, rd_val);  check("t5_count", rd_val, 0);
    cfg_write(REG_LENGTH, 3);
    cfg_write(REG_BASE, 1);
    cfg_write(REG_STEP, 1);
    cfg_write(REG_CTRL, 32'h3);
    cfg_write(REG_LENGTH, 50);
    cfg_write(REG_BASE, 99);
    cfg_write(REG_STEP, 7);
    cfg_write(REG_CTRL, 32'h1);
    check("t5_still_run", state32, ST_RUN);
    check("t5_shadow_data", tdata32, 1);
    exp_q = '{32'd1, 32'd2, 32'd3};
    stream(0, 100, 1'b0);
    cfg_read(REG_LENGTH, rd_val); check("t5_length_reg", rd_val, 50);
    cfg_read(REG_COUNT, rd_val);  check("t5_count_run", rd_val, 3);
    cfg_read(REG_STATUS, rd_val); check("t5_status_run", rd_val, 32'h2);

    // 6: reset mid-run
    cfg_write(REG_LENGTH, 10);
    cfg_write(REG_BASE, 0);
    cfg_write(REG_STEP, 1);
    cfg_write(REG_CTRL, 32'h1);
    axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_mid_valid", tvalid32, 1);
    check("t6_mid_data", tdata32, 3);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", tvalid32, 0);
    check("t6_last", tlast32, 0);
    check("t6_data", tdata32, 0);
    check("t6_state", state32, ST_IDLE);
    rst = 1'b0;
    axis_tready = 1'b0;
    cfg_read(REG_STATUS, rd_val); check("t6_status", rd_val, 0);
    cfg_read(REG_COUNT, rd_val);  check("t6_count", rd_val, 0);
    cfg_read(REG_LENGTH, rd_val); check("t6_length", rd_val, 0);
    cfg_read(31, rd_val);         check("t6_unmapped", rd_val, 0);
    @(negedge clk);
    check("t6_rd_idle", rd_data32, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
